// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter that shares one single-port synchronous RAM between two
// requesters and returns read data to whichever requester issued the read.
module mem_rr_arbiter #(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [AWIDTH-1:0]     req0_addr,
  input  logic [DWIDTH-1:0]     req0_wdata,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,

  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [AWIDTH-1:0]     req1_addr,
  input  logic [DWIDTH-1:0]     req1_wdata,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,

  output logic [DWIDTH-1:0]     rsp_rdata,

  output logic                  mem_en,
  output logic [DWIDTH/8-1:0]   mem_wbe,
  output logic [AWIDTH-1:0]     mem_addr,
  output logic [DWIDTH-1:0]     mem_din,
  input  logic [DWIDTH-1:0]     mem_dout,

  output logic                  busy
);

  localparam int BWIDTH = DWIDTH / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    RESP    = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                last_grant;
  logic                last_grant_nxt;
  logic                owner;
  logic                owner_nxt;
  logic                grant0;
  logic                grant1;
  logic                win_we;
  logic                owner_ready;
  logic [DWIDTH-1:0]   rdata_p1;

  function automatic logic [BWIDTH-1:0] byte_enables(input logic we);
    return {BWIDTH{we}};
  endfunction

  // On a tie the requester that did not win last time is served, so grants
  // alternate strictly while both requesters stay valid.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign win_we      = grant1 ? req1_we : req0_we;
  assign owner_ready = owner ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    owner_nxt      = owner;
    mem_en         = 1'b0;
    mem_wbe        = '0;
    mem_addr       = '0;
    mem_din        = '0;
    rsp0_valid     = 1'b0;
    rsp1_valid     = 1'b0;

    case (state)
      IDLE: begin
        if (grant0 || grant1) begin
          mem_en         = 1'b1;
          mem_addr       = grant1 ? req1_addr  : req0_addr;
          mem_din        = grant1 ? req1_wdata : req0_wdata;
          mem_wbe        = byte_enables(win_we);
          last_grant_nxt = grant1;
          // Writes complete in the RAM at this edge; only reads need a response.
          if (!win_we) begin
            owner_nxt = grant1;
            state_nxt = CAPTURE;
          end
        end
      end

      CAPTURE: begin
        state_nxt = RESP;
      end

      RESP: begin
        rsp0_valid = !owner;
        rsp1_valid = owner;
        if (owner_ready) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---- control registers / response data stage (p1) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      rdata_p1   <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      owner      <= owner_nxt;
      if (state == CAPTURE) begin
        rdata_p1 <= mem_dout;
      end
    end
  end

  assign rsp_rdata = rdata_p1;
  assign busy      = (state != IDLE);

endmodule
